// File: rtl/k423_if_id_queue.sv
// IF->ID decoupling queue: circular buffer of fetched packets (pc, inst,
// BPU prediction) with pass-through ready when full and flush on clear.
// Ports: clk_i/rst_n_i; pcu_clear_id_i, pcu_stall_id_i; if_* upstream
// packet + valid/ready; id_* head packet + valid/ready; id_queue_cnt_o.
module k423_if_id_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     pcu_clear_id_i,
  input  logic                     pcu_stall_id_i,
  input  logic                     if_stage_vld_i,
  output logic                     if_id_rdy_o,
  input  logic [ADDR_W-1:0]        if_pc_i,
  input  logic [INST_W-1:0]        if_inst_i,
  input  logic                     if_bpu_prd_tkn_i,
  input  logic [ADDR_W-1:0]        if_bpu_prd_pc_i,
  input  logic [1:0]               if_bpu_prd_sat_cnt_i,
  output logic                     id_stage_vld_o,
  input  logic                     id_stage_rdy_i,
  output logic [ADDR_W-1:0]        id_pc_o,
  output logic [INST_W-1:0]        id_inst_o,
  output logic                     id_bpu_prd_tkn_o,
  output logic [ADDR_W-1:0]        id_bpu_prd_pc_o,
  output logic [1:0]               id_bpu_prd_sat_cnt_o,
  output logic [$clog2(DEPTH):0]   id_queue_cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              tkn;
    logic [ADDR_W-1:0] tgt;
    logic [1:0]        sat;
  } pkt_t;

  pkt_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic empty, full, enq, deq, hs;
  pkt_t wr_pkt, head;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

  assign id_stage_vld_o = ~empty & ~pcu_stall_id_i;
  assign hs             = id_stage_vld_o & id_stage_rdy_i;
  // A dequeue in the same cycle frees the slot, so ready passes through.
  assign if_id_rdy_o    = ~full | hs;

  assign enq = if_stage_vld_i & if_id_rdy_o & ~pcu_clear_id_i;
  assign deq = hs & ~pcu_clear_id_i;

  assign wr_pkt = '{
    pc:   if_pc_i,
    inst: if_inst_i,
    tkn:  if_bpu_prd_tkn_i,
    tgt:  if_bpu_prd_pc_i,
    sat:  if_bpu_prd_sat_cnt_i
  };

  assign head = empty ? '0 : mem_q[rd_ptr_q];

  assign id_pc_o              = head.pc;
  assign id_inst_o            = head.inst;
  assign id_bpu_prd_tkn_o     = head.tkn;
  assign id_bpu_prd_pc_o      = head.tgt;
  assign id_bpu_prd_sat_cnt_o = head.sat;
  assign id_queue_cnt_o       = cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (pcu_clear_id_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
      unique case (1'b1)
        enq & ~deq: cnt_d = cnt_q + CW'(1);
        deq & ~enq: cnt_d = cnt_q - CW'(1);
        default:    cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // When full, wr_ptr == rd_ptr: the head is read combinationally
  // before this edge overwrites it.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_ptr_q] <= wr_pkt;
  end

endmodule

// File: tb/tb_k423_if_id_queue.sv
// Bench for k423_if_id_queue: queue-based reference model checked every
// negedge, plus directed scenarios with literal expectations.
module tb_k423_if_id_queue;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        pcu_clear_id_i = 1'b0;
  logic        pcu_stall_id_i = 1'b0;
  logic        if_stage_vld_i = 1'b0;
  logic        if_id_rdy_o;
  logic [31:0] if_pc_i = '0;
  logic [31:0] if_inst_i = '0;
  logic        if_bpu_prd_tkn_i = 1'b0;
  logic [31:0] if_bpu_prd_pc_i = '0;
  logic [1:0]  if_bpu_prd_sat_cnt_i = '0;
  logic        id_stage_vld_o;
  logic        id_stage_rdy_i = 1'b0;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_bpu_prd_tkn_o;
  logic [31:0] id_bpu_prd_pc_o;
  logic [1:0]  id_bpu_prd_sat_cnt_o;
  logic [2:0]  id_queue_cnt_o;

  k423_if_id_queue #(.DEPTH(DEPTH), .ADDR_W(32), .INST_W(32)) dut (
    .clk_i(clk_i),
    .rst_n_i(rst_n_i),
    .pcu_clear_id_i(pcu_clear_id_i),
    .pcu_stall_id_i(pcu_stall_id_i),
    .if_stage_vld_i(if_stage_vld_i),
    .if_id_rdy_o(if_id_rdy_o),
    .if_pc_i(if_pc_i),
    .if_inst_i(if_inst_i),
    .if_bpu_prd_tkn_i(if_bpu_prd_tkn_i),
    .if_bpu_prd_pc_i(if_bpu_prd_pc_i),
    .if_bpu_prd_sat_cnt_i(if_bpu_prd_sat_cnt_i),
    .id_stage_vld_o(id_stage_vld_o),
    .id_stage_rdy_i(id_stage_rdy_i),
    .id_pc_o(id_pc_o),
    .id_inst_o(id_inst_o),
    .id_bpu_prd_tkn_o(id_bpu_prd_tkn_o),
    .id_bpu_prd_pc_o(id_bpu_prd_pc_o),
    .id_bpu_prd_sat_cnt_o(id_bpu_prd_sat_cnt_o),
    .id_queue_cnt_o(id_queue_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        tkn;
    logic [31:0] tgt;
    logic [1:0]  sat;
  } pkt_t;

  pkt_t        mq[$];
  logic [31:0] dlog[$];
  int          checks = 0;
  int          errors = 0;

  function automatic pkt_t mk(input logic [31:0] pc);
    pkt_t p;
    p.pc   = pc;
    p.inst = ~pc ^ 32'h1357_9bdf;
    p.tkn  = pc[2];
    p.tgt  = pc + 32'h100;
    p.sat  = pc[3:2];
    return p;
  endfunction

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic drv(input logic v, input logic [31:0] pc,
                     input logic r, input logic s, input logic c);
    pkt_t p;
    p = mk(pc);
    if_stage_vld_i       = v;
    if_pc_i              = p.pc;
    if_inst_i            = p.inst;
    if_bpu_prd_tkn_i     = p.tkn;
    if_bpu_prd_pc_i      = p.tgt;
    if_bpu_prd_sat_cnt_i = p.sat;
    id_stage_rdy_i       = r;
    pcu_stall_id_i       = s;
    pcu_clear_id_i       = c;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cyc(input logic v, input logic [31:0] pc,
                     input logic r, input logic s, input logic c);
    drv(v, pc, r, s, c);
    tick();
  endtask

  task automatic chk_log(input string nm, input int base,
                         input logic [31:0] exp[$]);
    chk({nm, "_len"}, 32'(dlog.size() - base), 32'(exp.size()));
    foreach (exp[i])
      if (base + i < dlog.size())
        chk(nm, dlog[base + i], exp[i]);
  endtask

  // Model: an ordered list of packets; ready/valid derived from its size.
  task automatic compare_and_step();
    pkt_t        h;
    logic        m_vld, m_rdy, m_deq;
    h     = '{pc: '0, inst: '0, tkn: 1'b0, tgt: '0, sat: '0};
    if (mq.size() != 0) h = mq[0];
    m_vld = (mq.size() != 0) && !pcu_stall_id_i;
    m_deq = m_vld && id_stage_rdy_i;
    m_rdy = (mq.size() != DEPTH) || m_deq;
    chk("vld", 32'(id_stage_vld_o), 32'(m_vld));
    chk("rdy", 32'(if_id_rdy_o), 32'(m_rdy));
    chk("cnt", 32'(id_queue_cnt_o), 32'(mq.size()));
    chk("pc", id_pc_o, h.pc);
    chk("inst", id_inst_o, h.inst);
    chk("tkn", 32'(id_bpu_prd_tkn_o), 32'(h.tkn));
    chk("tgt", id_bpu_prd_pc_o, h.tgt);
    chk("sat", 32'(id_bpu_prd_sat_cnt_o), 32'(h.sat));
    if (rst_n_i) begin
      if (pcu_clear_id_i) begin
        mq.delete();
      end else begin
        if (id_stage_vld_o && id_stage_rdy_i) dlog.push_back(id_pc_o);
        if (m_deq) void'(mq.pop_front());
        if (if_stage_vld_i && m_rdy) mq.push_back(mk(if_pc_i));
      end
    end
  endtask

  task automatic stimulus();
    int          base, idx;
    logic        acc;
    logic [4:0]  pat;
    logic [31:0] ex[$];

    #1;
    chk("rst_vld", 32'(id_stage_vld_o), 32'd0);
    chk("rst_cnt", 32'(id_queue_cnt_o), 32'd0);
    chk("rst_rdy", 32'(if_id_rdy_o), 32'd1);
    repeat (2) @(negedge clk_i);
    #1 rst_n_i = 1'b1;
    tick();

    base = dlog.size();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 32'(i * 4), 1'b1, 1'b0, 1'b0);
      chk("stream_cnt", 32'(id_queue_cnt_o), 32'd1);
    end
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("stream_cnt_end", 32'(id_queue_cnt_o), 32'd0);
    ex = '{32'h0, 32'h4, 32'h8, 32'hc};
    chk_log("stream_order", base, ex);

    base = dlog.size();
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b0);
    chk("fill_cnt", 32'(id_queue_cnt_o), 32'd4);
    drv(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
    #1 chk("fill_rdy_low", 32'(if_id_rdy_o), 32'd0);
    tick();
    chk("fill_hold_cnt", 32'(id_queue_cnt_o), 32'd4);
    drv(1'b1, 32'h10, 1'b1, 1'b0, 1'b0);
    #1 chk("fill_rdy_pass", 32'(if_id_rdy_o), 32'd1);
    tick();
    chk("fill_pass_cnt", 32'(id_queue_cnt_o), 32'd4);
    chk("fill_head", id_pc_o, 32'h4);
    repeat (5) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    ex = '{32'h0, 32'h4, 32'h8, 32'hc, 32'h10};
    chk_log("fill_order", base, ex);

    base = dlog.size();
    idx  = 0;
    pat  = 5'b01101;
    for (int c = 0; c < 80 && dlog.size() < base + 10; c++) begin
      drv(idx < 10, 32'h100 + 32'(idx * 4), pat[c % 5], 1'b0, 1'b0);
      #1 acc = (idx < 10) && if_id_rdy_o;
      tick();
      if (acc) idx++;
    end
    ex.delete();
    for (int i = 0; i < 10; i++) ex.push_back(32'h100 + 32'(i * 4));
    chk_log("wrap_order", base, ex);

    for (int i = 0; i < 3; i++)
      cyc(1'b1, 32'h20 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
    chk("flush_pre_cnt", 32'(id_queue_cnt_o), 32'd3);
    cyc(1'b1, 32'h40, 1'b0, 1'b0, 1'b1);
    chk("flush_cnt", 32'(id_queue_cnt_o), 32'd0);
    chk("flush_vld", 32'(id_stage_vld_o), 32'd0);
    base = dlog.size();
    cyc(1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
    chk("flush_head", id_pc_o, 32'h80);
    chk("flush_head_vld", 32'(id_stage_vld_o), 32'd1);
    repeat (2) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    ex = '{32'h80};
    chk_log("flush_order", base, ex);

    cyc(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h204, 1'b0, 1'b0, 1'b0);
    base = dlog.size();
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      chk("stall_vld", 32'(id_stage_vld_o), 32'd0);
      chk("stall_cnt", 32'(id_queue_cnt_o), 32'd2);
      chk("stall_pc", id_pc_o, 32'h200);
    end
    repeat (2) cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    ex = '{32'h200, 32'h204};
    chk_log("stall_order", base, ex);
    cyc(1'b1, 32'h208, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h20c, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h210, 1'b1, 1'b1, 1'b1);
    chk("stall_clear_cnt", 32'(id_queue_cnt_o), 32'd0);

    cyc(1'b1, 32'h304, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h30c, 1'b0, 1'b0, 1'b0);
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("areset_pre_tkn", 32'(id_bpu_prd_tkn_o), 32'd1);
    chk("areset_pre_cnt", 32'(id_queue_cnt_o), 32'd2);
    rst_n_i = 1'b0;
    #1;
    chk("areset_vld", 32'(id_stage_vld_o), 32'd0);
    chk("areset_cnt", 32'(id_queue_cnt_o), 32'd0);
    @(negedge clk_i);
    #1 rst_n_i = 1'b1;
    tick();
    chk("areset_rdy", 32'(if_id_rdy_o), 32'd1);
    chk("areset_cnt_after", 32'(id_queue_cnt_o), 32'd0);
    tick();
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk_i);
        compare_and_step();
      end
      forever begin
        @(negedge rst_n_i);
        mq.delete();
      end
    join_none
    stimulus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
